reg_load_arbiter: RTL

- Shares the load port of a bank of 16-bit enable-gated registers among several requesters (fetch unit, ALU writeback, load unit, debug).
- Grants one requester per cycle, round-robin.
- Drives a registered shared data bus plus a one-hot clock-enable vector, one bit per register's CE input.
- Supports locked bursts, so one requester can own the bank for consecutive writes.

---
 rtl/reg_load_arbiter_pkg.sv | 29 ++
 rtl/reg_load_arbiter_if.sv | 31 +++
 rtl/reg_load_arbiter_rr_pick.sv | 44 ++++
 rtl/reg_load_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/reg_load_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// reg_load_arbiter_pkg : state encoding, default widths, decode helpers
// Rev 1.0
// ============================================================================
package reg_load_arbiter_pkg;

  localparam int N_DEF    = 16;
  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 6;
  localparam int AW_DEF   = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Wide one-hot decode; callers size-cast down to the vector they drive.
  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

  // Modulo increment by explicit compare, so n need not be a power of two.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_load_arbiter_if.sv
`default_nettype none
// ============================================================================
// reg_load_arbiter_if : requester-side handshake and register-bank load bus
// Rev 1.0
// ============================================================================
interface reg_load_arbiter_if #(
  parameter int N    = 16,
  parameter int NREQ = 4,
  parameter int NREG = 6,
  parameter int AW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*N-1:0]  wdata;
  logic [NREQ-1:0]    gnt;
  logic [N-1:0]       D_out;
  logic [NREG-1:0]    CE_out;
  logic               addr_err;

  modport master (
    output req, lock, addr, wdata,
    input  gnt, D_out, CE_out, addr_err
  );

  modport slave (
    input  req, lock, addr, wdata,
    output gnt, D_out, CE_out, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_load_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin picker, first request at or after ptr
// Rev 1.0
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  int unsigned     p;
  int unsigned     rank;
  int unsigned     best_rank;
  int unsigned     best_idx;
  logic [NREQ-1:0] req_sh;

  // Each requester's distance from ptr going forward with wrap; the
  // smallest distance among active requests wins.
  always_comb begin
    p         = 32'(ptr);
    rank      = 32'd0;
    best_rank = NREQ;
    best_idx  = 32'd0;
    req_sh    = '0;
    valid     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      req_sh = req >> i;
      rank   = (i >= p) ? i - p : i + NREQ - p;
      if (req_sh[0] && (rank < best_rank)) begin
        best_rank = rank;
        best_idx  = i;
        valid     = 1'b1;
      end
    end
    gnt = valid ? (NREQ'(1) << best_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// reg_load_arbiter : round-robin, lockable arbiter for a register-bank load port
// Rev 1.0
// ============================================================================
module reg_load_arbiter
  import reg_load_arbiter_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic             C,
  input  logic             CLR,
  reg_load_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [N-1:0]    d_out_q, d_out_d;
  logic [NREG-1:0] ce_out_q, ce_out_d;
  logic            addr_err_q, addr_err_d;

  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] pick_gnt;
  logic [NREQ-1:0] gnt_sh;
  logic            pick_valid;
  logic            accept;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   gnt_addr;
  logic [N-1:0]    gnt_data;

  // While locked only the owner is visible to the picker.
  always_comb begin
    req_eff = bus.req;
    if (state_q == ST_LOCKED) begin
      req_eff = bus.req & (NREQ'(1) << owner_q);
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req   (req_eff),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    gnt_idx = '0;
    gnt_sh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_sh = pick_gnt >> i;
      if (gnt_sh[0]) begin
        gnt_idx = PW'(i);
      end
    end
  end

  assign gnt_addr = AW'(bus.addr >> (32'(gnt_idx) * AW));
  assign gnt_data = N'(bus.wdata >> (32'(gnt_idx) * N));
  assign accept   = pick_valid && !CLR;
  assign bus.gnt  = CLR ? '0 : pick_gnt;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    d_out_d    = d_out_q;
    ce_out_d   = '0;
    addr_err_d = 1'b0;

    // Out-of-range writes are still consumed, just without a CE pulse.
    if (accept) begin
      d_out_d = gnt_data;
      if (32'(gnt_addr) < NREG) begin
        ce_out_d = NREG'(onehot(32'(gnt_addr)));
      end else begin
        addr_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ptr_d = PW'(wrap_inc(32'(gnt_idx), NREQ));
          if (bus.lock[gnt_idx]) begin
            state_d = ST_LOCKED;
            owner_d = gnt_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (!(bus.req[owner_q] && bus.lock[owner_q])) begin
          state_d = ST_IDLE;
          ptr_d   = PW'(wrap_inc(32'(owner_q), NREQ));
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      d_out_q    <= '0;
      ce_out_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      d_out_q    <= d_out_d;
      ce_out_q   <= ce_out_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.D_out    = d_out_q;
  assign bus.CE_out   = ce_out_q;
  assign bus.addr_err = addr_err_q;

endmodule
`default_nettype wire
